// File: rtl/ddr2_local_responder_pkg.sv
// Shared types and widths for the DDR2 local-interface responder.
// Imported by the interface, the latency pipe and the top.
package ddr2_local_pkg;

  localparam int LOCAL_DW  = 32;
  localparam int LOCAL_BEW = 4;
  localparam int SIZE_W    = 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH
  } state_e;

  // A burst size of zero on the local bus means a single beat
  function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
    return (s == '0) ? SIZE_W'(1) : s;
  endfunction

endpackage

// File: rtl/ddr2_local_responder_if.sv
// DDR2 controller-core local interface bundle.
// The master drives requests; the slave (responder) drives the handshake and read data.
interface ddr2_local_if #(
  parameter int ADDR_W = 28
);
  import ddr2_local_pkg::*;

  logic [ADDR_W-1:0]    local_address;
  logic [LOCAL_BEW-1:0] local_be;
  logic                 local_burstbegin;
  logic [SIZE_W-1:0]    local_size;
  logic [LOCAL_DW-1:0]  local_wdata;
  logic                 local_write_req;
  logic                 local_read_req;
  logic                 local_ready;
  logic [LOCAL_DW-1:0]  local_rdata;
  logic                 local_rdata_valid;
  logic                 local_init_done;
  logic                 local_refresh_ack;

  modport master (
    output local_address, local_be, local_burstbegin, local_size, local_wdata,
           local_write_req, local_read_req,
    input  local_ready, local_rdata, local_rdata_valid, local_init_done, local_refresh_ack
  );

  modport slave (
    input  local_address, local_be, local_burstbegin, local_size, local_wdata,
           local_write_req, local_read_req,
    output local_ready, local_rdata, local_rdata_valid, local_init_done, local_refresh_ack
  );

endinterface

// File: rtl/ddr2_local_responder_rd_lat_pipe.sv
// Fixed-latency read return path: DEPTH-stage valid+data shift register.
// Only the valid bits are reset, so a reset discards every in-flight beat.
module ddr2_rd_lat_pipe #(
  parameter int DEPTH = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DW-1:0]    data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data stages only load behind a valid beat
  always_ff @(posedge clk) begin
    if (vld_i) data_q[0] <= data_i;
    for (int i = 1; i < DEPTH; i++) begin
      if (vld_q[i-1]) data_q[i] <= data_q[i-1];
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/ddr2_local_responder.sv
// On-chip stand-in for a DDR2 controller core: init delay, refresh stalls,
// burst writes with byte enables and fixed-latency burst reads from local RAM.
module ddr2_local_responder
  import ddr2_local_pkg::*;
#(
  parameter int ADDR_W           = 28,
  parameter int MEM_AW           = 12,
  parameter int INIT_CYCLES      = 64,
  parameter int RD_LAT           = 6,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 16,
  parameter bit ASSERT_EN        = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  ddr2_local_if.slave  bus
);

  localparam int CNT_MAX = (INIT_CYCLES > REFRESH_CYCLES) ? INIT_CYCLES : REFRESH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RF_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RF_W-1:0]     ref_cnt_q, ref_cnt_d;
  logic [MEM_AW-1:0]   base_q, base_d;
  logic [SIZE_W-1:0]   size_q, size_d, beat_q, beat_d, req_size;
  logic                ready_q, ready_d, init_done_q, init_done_d;
  logic                pend_q, pend_d, ack_q, ack_d;
  logic                acc_wr, acc_rd, wr_en, rd_issue;
  logic [MEM_AW-1:0]   wr_addr, beat_addr;
  logic [LOCAL_DW-1:0] mem [0:(1<<MEM_AW)-1];
  logic [LOCAL_DW-1:0] pipe_data;
  logic                pipe_vld;
  logic                unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      base_q      <= '0;
      size_q      <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      base_q      <= base_d;
      size_q      <= size_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_cnt_d   = ref_cnt_q;
    base_d      = base_q;
    size_d      = size_q;
    beat_d      = beat_q;
    init_done_d = init_done_q;
    pend_d      = pend_q;
    ack_d       = 1'b0;
    wr_en       = 1'b0;
    rd_issue    = 1'b0;
    beat_addr   = base_q + MEM_AW'(beat_q);
    wr_addr     = beat_addr;
    req_size    = eff_size(bus.local_size);
    acc_wr      = ready_q && bus.local_write_req &&
                  ((state_q == ST_IDLE) || (state_q == ST_WRITE));
    acc_rd      = ready_q && bus.local_read_req && !bus.local_write_req &&
                  (state_q == ST_IDLE);

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        // Requests beat refresh; a pending refresh simply waits for a quiet cycle
        if (acc_wr) begin
          wr_en   = 1'b1;
          wr_addr = bus.local_address[MEM_AW-1:0];
          if (req_size != SIZE_W'(1)) begin
            state_d = ST_WRITE;
            base_d  = bus.local_address[MEM_AW-1:0];
            size_d  = req_size;
            beat_d  = SIZE_W'(1);
          end
        end else if (acc_rd) begin
          state_d = ST_READ;
          base_d  = bus.local_address[MEM_AW-1:0];
          size_d  = req_size;
          beat_d  = '0;
        end else if (pend_q) begin
          state_d = ST_REFRESH;
          pend_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_WRITE: begin
        if (acc_wr) begin
          wr_en = 1'b1;
          if (beat_q == size_q - SIZE_W'(1)) state_d = ST_IDLE;
          else                               beat_d  = beat_q + SIZE_W'(1);
        end
      end
      ST_READ: begin
        rd_issue = 1'b1;
        if (beat_q == size_q - SIZE_W'(1)) state_d = ST_IDLE;
        else                               beat_d  = beat_q + SIZE_W'(1);
      end
      ST_REFRESH: begin
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Evaluated after the FSM so a new interval is never lost to a same-cycle refresh start
    if (init_done_q) begin
      if (ref_cnt_q == RF_W'(REFRESH_INTERVAL - 1)) begin
        ref_cnt_d = '0;
        pend_d    = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + RF_W'(1);
      end
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < LOCAL_BEW; b++) begin
        if (bus.local_be[b]) mem[wr_addr][8*b +: 8] <= bus.local_wdata[8*b +: 8];
      end
    end
  end

  ddr2_rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .DW    (LOCAL_DW)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_issue),
    .data_i (mem[beat_addr]),
    .vld_o  (pipe_vld),
    .data_o (pipe_data)
  );

  assign bus.local_ready       = ready_q;
  assign bus.local_rdata       = pipe_vld ? pipe_data : '0;
  assign bus.local_rdata_valid = pipe_vld;
  assign bus.local_init_done   = init_done_q;
  assign bus.local_refresh_ack = ack_q;

  // Upper address bits alias by design; burstbegin carries no extra information here
  assign unused_bits = ^{bus.local_burstbegin, bus.local_address[ADDR_W-1:MEM_AW]};

  if (ASSERT_EN) begin : g_proto_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == ST_IDLE) && bus.local_write_req && bus.local_read_req));
  end

endmodule

// File: tb/tb_ddr2_local_responder.sv
// Bench for ddr2_local_responder: vector table, hand-built corner sequences and
// random traffic scored against a word-array memory model with cycle-stamped read expectations.
module tb_ddr2_local_responder;

  localparam int ADDR_W           = 28;
  localparam int MEM_AW           = 12;
  localparam int INIT_CYCLES      = 64;
  localparam int RD_LAT           = 6;
  localparam int REFRESH_INTERVAL = 780;
  localparam int REFRESH_CYCLES   = 16;
  localparam int MEM_N            = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_local_if #(.ADDR_W(ADDR_W)) bus();

  ddr2_local_responder #(
    .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT),
    .REFRESH_INTERVAL(REFRESH_INTERVAL), .REFRESH_CYCLES(REFRESH_CYCLES), .ASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int cyc; logic [31:0] data; logic [31:0] mask; } exp_t;
  typedef struct { bit rd; logic [27:0] addr; logic [2:0] size; logic [31:0] d; logic [3:0] be; } vec_t;

  logic [31:0] ref_mem   [MEM_N];
  logic [3:0]  ref_known [MEM_N];
  exp_t        exp_q[$];
  vec_t        tab[15];
  int          tests = 0, fails = 0, cyc = 0, acks = 0;
  bit          in_wr_burst = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input logic [2:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.local_write_req  = 1'b0;
    bus.local_read_req   = 1'b0;
    bus.local_burstbegin = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.local_ready && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check(1'b0, name, 32'(n), 32'd300);
  endtask

  task automatic do_write(input logic [27:0] addr, input logic [2:0] size,
                          input logic [31:0] d0, input logic [3:0] be);
    int  n = eff(size);
    bit  rdy_ok = 1'b1;
    int  a;
    logic [31:0] wd;
    for (int i = 0; i < n; i++) begin
      wd = d0 + 32'(i);
      bus.local_write_req  = 1'b1;
      bus.local_read_req   = 1'b0;
      bus.local_address    = addr;
      bus.local_size       = size;
      bus.local_wdata      = wd;
      bus.local_be         = be;
      bus.local_burstbegin = (i == 0);
      if (i == 0) begin
        wait_ready("wr_wait_timeout");
        in_wr_burst = 1'b1;
      end else if (!bus.local_ready) begin
        rdy_ok = 1'b0;
      end
      a = (int'(addr[MEM_AW-1:0]) + i) % MEM_N;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          ref_known[a][b]      = 1'b1;
        end
      end
      step();
    end
    drive_idle();
    in_wr_burst = 1'b0;
    if (n > 1) check(rdy_ok, "wr_burst_ready", 32'(rdy_ok), 32'd1);
  endtask

  task automatic do_read(input logic [27:0] addr, input logic [2:0] size,
                         input bit use_tab, input logic [31:0] d_exp);
    int   n = eff(size);
    bit   win = 1'b1;
    int   a;
    exp_t e;
    bus.local_read_req   = 1'b1;
    bus.local_write_req  = 1'b0;
    bus.local_address    = addr;
    bus.local_size       = size;
    bus.local_burstbegin = 1'b1;
    wait_ready("rd_wait_timeout");
    for (int i = 0; i < n; i++) begin
      a      = (int'(addr[MEM_AW-1:0]) + i) % MEM_N;
      e.cyc  = cyc + 1 + RD_LAT + i;
      e.data = use_tab ? d_exp + 32'(i) : ref_mem[a];
      e.mask = use_tab ? 32'hFFFF_FFFF : mask_of(ref_known[a]);
      exp_q.push_back(e);
    end
    step();
    drive_idle();
    for (int i = 0; i < n; i++) begin
      if (bus.local_ready) win = 1'b0;
      step();
    end
    check(win && bus.local_ready, "rd_ready_window", {31'd0, win & bus.local_ready}, 32'd1);
  endtask

  task automatic init_check();
    int n = 0;
    bit pre_ok = 1'b1;
    while (!bus.local_ready && n < 300) begin
      if (bus.local_init_done || bus.local_refresh_ack) pre_ok = 1'b0;
      step();
      n++;
    end
    check(n == INIT_CYCLES + 1, "init_latency", 32'(n), 32'(INIT_CYCLES + 1));
    check(bus.local_init_done && !bus.local_refresh_ack && pre_ok, "init_done_rise",
          {30'd0, bus.local_init_done, pre_ok}, 32'd3);
  endtask

  // Read-return and refresh-window monitor
  initial begin
    exp_t e;
    int   ref_left = 0;
    bit   ref_ok = 1'b1, ref_end = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        ref_left = 0;
        ref_end  = 1'b0;
        if (bus.local_rdata_valid) check(1'b0, "rst_valid", 32'd1, 32'd0);
      end else begin
        if (bus.local_rdata_valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "rd_unexpected", bus.local_rdata, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) check(1'b0, "rd_latency", 32'(cyc), 32'(e.cyc));
            else check(((bus.local_rdata ^ e.data) & e.mask) == 32'd0, "rd_data", bus.local_rdata, e.data);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check(1'b0, "rd_missing", 32'(cyc), 32'(e.cyc));
        end
        if (ref_end) begin
          check(bus.local_ready && ref_ok, "ref_window", {30'd0, bus.local_ready, ref_ok}, 32'd3);
          ref_end = 1'b0;
        end
        if (bus.local_refresh_ack) begin
          check(ref_left == 0 && !in_wr_burst, "ref_ack_start", 32'(ref_left), 32'd0);
          acks++;
          ref_left = REFRESH_CYCLES;
          ref_ok   = 1'b1;
        end
        if (ref_left > 0) begin
          if (bus.local_ready) ref_ok = 1'b0;
          if (bus.local_refresh_ack && ref_left != REFRESH_CYCLES) ref_ok = 1'b0;
          ref_left--;
          if (ref_left == 0) ref_end = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [27:0] ra;
    logic [2:0]  rs;

    tab[0]  = '{1'b0, 28'h0000010, 3'd4, 32'h0000_00A0, 4'hF};
    tab[1]  = '{1'b1, 28'h0000010, 3'd4, 32'h0000_00A0, 4'hF};
    tab[2]  = '{1'b0, 28'h0000020, 3'd1, 32'h1122_3344, 4'hF};
    tab[3]  = '{1'b0, 28'h0000020, 3'd1, 32'hFFFF_FFFF, 4'h5};
    tab[4]  = '{1'b1, 28'h0000020, 3'd1, 32'h11FF_33FF, 4'hF};
    tab[5]  = '{1'b0, 28'h0001000, 3'd0, 32'hCAFE_0001, 4'hF};
    tab[6]  = '{1'b1, 28'h0000000, 3'd0, 32'hCAFE_0001, 4'hF};
    tab[7]  = '{1'b0, 28'h0000030, 3'd2, 32'h0000_0000, 4'hF};
    tab[8]  = '{1'b0, 28'h0000030, 3'd2, 32'h1234_ABCD, 4'h3};
    tab[9]  = '{1'b1, 28'h0000030, 3'd2, 32'h0000_ABCD, 4'hF};
    tab[10] = '{1'b0, 28'h0000FFE, 3'd3, 32'h0000_0100, 4'hF};
    tab[11] = '{1'b1, 28'h0007FFE, 3'd3, 32'h0000_0100, 4'hF};
    tab[12] = '{1'b0, 28'h0000040, 3'd7, 32'h0000_0070, 4'hF};
    tab[13] = '{1'b1, 28'h0000040, 3'd7, 32'h0000_0070, 4'hF};
    tab[14] = '{1'b1, 28'h0001000, 3'd1, 32'h0000_0102, 4'hF};

    for (int i = 0; i < MEM_N; i++) begin
      ref_mem[i]   = 32'd0;
      ref_known[i] = 4'd0;
    end
    bus.local_address = '0;
    bus.local_size    = '0;
    bus.local_wdata   = '0;
    bus.local_be      = '0;
    drive_idle();

    rst_n = 1'b0;
    repeat (3) step();
    check({bus.local_ready, bus.local_rdata_valid, bus.local_init_done, bus.local_refresh_ack} == 4'd0
          && bus.local_rdata == 32'd0, "reset_outputs",
          {28'd0, bus.local_ready, bus.local_rdata_valid, bus.local_init_done, bus.local_refresh_ack}, 32'd0);
    rst_n = 1'b1;
    init_check();

    for (int i = 0; i < 15; i++) begin
      if (tab[i].rd) do_read(tab[i].addr, tab[i].size, 1'b1, tab[i].d);
      else           do_write(tab[i].addr, tab[i].size, tab[i].d, tab[i].be);
    end

    // Write and read together in IDLE: only the write takes effect
    bus.local_write_req  = 1'b1;
    bus.local_read_req   = 1'b1;
    bus.local_address    = 28'h0000050;
    bus.local_size       = 3'd1;
    bus.local_wdata      = 32'h0000_0077;
    bus.local_be         = 4'hF;
    bus.local_burstbegin = 1'b1;
    wait_ready("collide_wait_timeout");
    ref_mem[16'h50]   = 32'h0000_0077;
    ref_known[16'h50] = 4'hF;
    step();
    drive_idle();
    check(bus.local_ready, "collide_stays_idle", {31'd0, bus.local_ready}, 32'd1);
    repeat (RD_LAT + 2) step();
    do_read(28'h0000050, 3'd1, 1'b1, 32'h0000_0077);

    // Random traffic with idle gaps so refresh gets a chance
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 3)) step();
      ra = ($urandom() & 28'hFFFF000) | 28'(12'h100 + $urandom_range(0, 63));
      rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) do_write(ra, rs, $urandom(), 4'($urandom_range(0, 15)));
      else                           do_read(ra, rs, 1'b0, 32'd0);
    end
    repeat (RD_LAT + 4) step();
    check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
    check(acks > 0, "refresh_seen", 32'(acks), 32'd1);

    // Reset two beats into a four-beat read
    do_write(28'h0000060, 3'd4, 32'h0000_00B0, 4'hF);
    bus.local_read_req   = 1'b1;
    bus.local_address    = 28'h0000060;
    bus.local_size       = 3'd4;
    bus.local_burstbegin = 1'b1;
    wait_ready("rst_rd_wait_timeout");
    step();
    drive_idle();
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check(!bus.local_rdata_valid && !bus.local_init_done && !bus.local_ready && bus.local_rdata == 32'd0,
          "rst_midread", {29'd0, bus.local_rdata_valid, bus.local_init_done, bus.local_ready}, 32'd0);
    repeat (RD_LAT + 4) step();
    rst_n = 1'b1;
    init_check();
    do_read(28'h0000060, 3'd4, 1'b1, 32'h0000_00B0);
    repeat (RD_LAT + 4) step();
    check(exp_q.size() == 0, "final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
